// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state encoding shared by the sequential ALU
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add unsigned multiplier, one partial product per clock
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;

    // The final partial sum is exposed combinationally so the caller can
    // capture it on the same edge as the last iteration.
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = run_q && (cnt_q == CW'(WIDTH - 1));
    assign product_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            acc_q    <= '0;
            mplier_q <= b_i;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            run_q    <= !done_o;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshake, flags and sequential multiply
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy
);
    state_e             state_q, state_d;
    logic               accept, is_mul, mul_start, mul_done, mul_hi;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d, ovf_q, ovf_d, zero_q, neg_q, load;

    assign accept    = in_valid & in_ready;
    assign is_mul    = (sel == OP_MUL);
    assign mul_start = accept & is_mul;
    assign mul_hi    = |mul_prod[2*WIDTH-1:WIDTH];

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (A),
        .b_i       (B),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_mul ? ST_MUL : ST_HOLD;
            ST_MUL:  if (mul_done) state_d = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    if (accept) state_d = is_mul ? ST_MUL : ST_HOLD;
                    else        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // HOLD passes out_ready through so a new op can enter as the result leaves.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = rst_n;
            ST_MUL:  busy = 1'b1;
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (sel)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = ~diff_ext[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_NOT: alu_res = ~A;
            OP_XOR: alu_res = A ^ B;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: ;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        result_d = alu_res;
        carry_d  = alu_c;
        ovf_d    = alu_v;
        if (mul_done) begin
            load     = 1'b1;
            result_d = mul_prod[WIDTH-1:0];
            carry_d  = mul_hi;
            ovf_d    = mul_hi;
        end else if (accept && !is_mul) begin
            load = 1'b1;
        end
    end

    // zero/negative are registered so they read 0 out of reset like the other flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else if (load) begin
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= (result_d == '0);
            neg_q    <= result_d[WIDTH-1];
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign negative = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic           in_valid = 1'b0, out_ready = 1'b1;
    logic           in_ready, out_valid, carry, overflow, zero, negative, busy;
    logic [W-1:0]   A = '0, B = '0, result;
    logic [2:0]     sel = 3'd0;

    logic           v8 = 1'b0, or8 = 1'b1;
    logic           ir8, ov8, c8, vv8, z8, n8, b8;
    logic [7:0]     a8 = '0, bb8 = '0, res8;
    logic [2:0]     s8 = 3'd0;

    int n_assert = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        longint r;
        bit     c;
        bit     v;
    } exp_t;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow), .zero(zero),
        .negative(negative), .busy(busy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
        .A(a8), .B(bb8), .sel(s8), .out_valid(ov8), .out_ready(or8),
        .result(res8), .carry(c8), .overflow(vv8), .zero(z8),
        .negative(n8), .busy(b8)
    );

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t ref_op(input int op, input longint a, input longint b, input int w);
        exp_t   e;
        longint m, half, sa, sb, t;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        e.r = 0; e.c = 0; e.v = 0;
        case (op)
            0: begin t = a + b; e.r = t & m; e.c = (t > m);
                     e.v = (sa + sb > half - 1) || (sa + sb < -half); end
            1: begin e.r = (a - b) & m; e.c = (a >= b);
                     e.v = (sa - sb > half - 1) || (sa - sb < -half); end
            2: e.r = a & b;
            3: e.r = a | b;
            4: e.r = ~a & m;
            5: e.r = a ^ b;
            6: begin t = a * b; e.r = t & m; e.c = ((t >> w) != 0); e.v = e.c; end
            default: e.r = (sa < sb) ? 1 : 0;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model of the width-4 instance: pending result, remaining multiply cycles.
    int   m_left  = 0;
    bit   m_valid = 1'b0;
    exp_t m_cur, m_pend;

    always @(negedge clk) begin : model
        bit   exp_ir;
        exp_t e;
        if (!rst_n) begin
            m_left  = 0;
            m_valid = 1'b0;
            check("rst in_ready", in_ready, 0);
            check("rst out_valid", out_valid, 0);
            check("rst busy", busy, 0);
            check("rst result", result, 0);
            check("rst flags", {carry, overflow, zero, negative}, 0);
        end else begin
            exp_ir = (m_left == 0) && (!m_valid || out_ready);
            check("in_ready", in_ready, exp_ir);
            check("busy", busy, m_left > 0);
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("result", result, m_cur.r);
                check("carry", carry, m_cur.c);
                check("overflow", overflow, m_cur.v);
                check("zero", zero, m_cur.r == 0);
                check("negative", negative, (m_cur.r >> (W - 1)) & 1);
                if (out_ready) xfer_cnt++;
            end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_cur   = m_pend;
                end
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (in_valid && exp_ir) begin
                    e = ref_op(int'(sel), longint'(A), longint'(B), W);
                    if (sel == 3'd6) begin
                        m_left = W;
                        m_pend = e;
                    end else begin
                        m_valid = 1'b1;
                        m_cur   = e;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        bit done = 1'b0;
        A = a; B = b; sel = op; in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            sync();
        end
        if (!done) check("send accept timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = out_valid;
            if (!ok) sync();
        end
        check(name, ok, 1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bit ok = 1'b0;
        a8 = a; bb8 = b; s8 = op; v8 = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = ir8;
            sync();
        end
        v8 = 1'b0;
        check("w8 accept", ok, 1);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = ov8;
            if (!ok) sync();
        end
        check("w8 out_valid", ok, 1);
    endtask

    initial begin
        exp_t        e;
        int          bcnt;
        int          start;
        logic [2:0]  ops[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
        logic [3:0]  lit[7] = '{4'd8, 4'd2, 4'd1, 4'd7, 4'd10, 4'd6, 4'd0};
        logic [7:0]  ra, rb;
        logic [2:0]  rop;

        #1 rst_n = 1'b0;
        repeat (3) sync();
        check("reset result", result, 0);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        #1 check("in_ready after release", in_ready, 1);

        e = ref_op(0, 5, 3, 4);
        check("model add", {e.r[7:0], e.c, e.v}, {8'd8, 1'b0, 1'b1});
        e = ref_op(6, 7, 3, 4);
        check("model mul", {e.r[7:0], e.c, e.v}, {8'd5, 1'b1, 1'b1});
        e = ref_op(1, 0, 1, 8);
        check("model sub w8", {e.r[7:0], e.c}, {8'hFF, 1'b0});

        sync();
        for (int i = 0; i < 7; i++) begin
            send(4'd5, 4'd3, ops[i]);
            @(negedge clk);
            check("op out_valid 1 cycle", out_valid, 1);
            check("op result", result, lit[i]);
            if (i == 0) check("add flags c/v/n", {carry, overflow, negative}, 3'b011);
            if (i == 1) check("sub carry", carry, 1);
            sync();
        end

        send(4'd5, 4'd3, 3'd6);
        bcnt = 0;
        for (int k = 0; k < 20 && !out_valid; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (!out_valid) sync();
        end
        check("mul busy cycles", bcnt, 4);
        check("mul 5*3", {result, carry}, {4'd15, 1'b0});
        sync();
        send(4'd7, 4'd3, 3'd6);
        wait_valid("mul 7*3 valid");
        check("mul 7*3", {result, carry, overflow}, {4'd5, 1'b1, 1'b1});
        sync();

        out_ready = 1'b0;
        send(4'd5, 4'd3, 3'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp held", {out_valid, in_ready, result, overflow}, {1'b1, 1'b0, 4'd8, 1'b1});
            sync();
        end
        out_ready = 1'b1;
        A = 4'd5; B = 4'd3; sel = 3'd1; in_valid = 1'b1;
        @(negedge clk);
        check("bp dual transfer", {in_ready, out_valid, result}, {1'b1, 1'b1, 4'd8});
        sync();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp queued sub", {out_valid, result, carry}, {1'b1, 4'd2, 1'b1});
        repeat (3) sync();

        start = xfer_cnt;
        for (int i = 0; i < 6; i++)
            send(4'($urandom), 4'($urandom), ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5);
        @(negedge clk);
        sync();
        check("stream transfers", xfer_cnt - start, 6);

        send(4'd7, 4'd7, 3'd6);
        sync();
        sync();
        #1 rst_n = 1'b0;
        #1 check("async reset", {busy, out_valid, in_ready, result, zero}, 0);
        repeat (2) sync();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no stale result", out_valid, 0);
        end
        sync();
        send(4'd1, 4'd1, 3'd0);
        @(negedge clk);
        check("add after reset", {out_valid, result}, {1'b1, 4'd2});
        sync();

        op8(8'hFF, 8'h01, 3'd0);
        check("w8 add", {res8, z8, c8, vv8}, {8'h00, 1'b1, 1'b1, 1'b0});
        sync();
        op8(8'h00, 8'h01, 3'd1);
        check("w8 sub", {res8, c8, n8}, {8'hFF, 1'b0, 1'b1});
        sync();
        op8(8'h80, 8'h01, 3'd7);
        check("w8 slt", res8, 8'h01);
        sync();
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
            e = ref_op(int'(rop), longint'(ra), longint'(rb), 8);
            op8(ra, rb, rop);
            check("w8 rand", {res8, c8, vv8, z8, n8},
                  {e.r[7:0], e.c, e.v, e.r[7:0] == 8'h00, e.r[7]});
            sync();
        end

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) sync();
            send(4'($urandom), 4'($urandom), 3'($urandom));
        end
        rand_rdy = 1'b0;
        sync();
        out_ready = 1'b1;
        for (int k = 0; k < 100 && (out_valid || busy); k++) sync();
        check("drain", {out_valid, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
